// File: rtl/lcd_text_writer_if.sv
// Byte-stream input handshake and display-RAM write bus for the text writer.
// The master side feeds characters and observes RAM writes; the slave is the writer.
interface lcd_text_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/lcd_text_writer.sv
// Text cursor and display-RAM writer for the 12864 character path: consumes bytes,
// handles CR/LF/BS/FF, and writes characters or a full-screen fill into the 4x16 RAM.
module lcd_text_writer #(
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_text_writer_if.slave     bus,
    output logic [1:0]           cursor_row,
    output logic [3:0]           cursor_col,
    output logic                 busy
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [7:0] C_BS = 8'h08;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_FF = 8'h0C;
    localparam logic [7:0] C_CR = 8'h0D;

    logic [0:0] state;
    logic [5:0] clr_cnt;
    logic       clr_done;
    logic       xfer;

    // in_ready is only ever high in IDLE, so it alone qualifies the handshake
    assign xfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            busy         <= CLEAR_ON_RESET;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= 6'd0;
            bus.wr_data  <= 8'd0;
            cursor_row   <= 2'd0;
            cursor_col   <= 4'd0;
            clr_cnt      <= 6'd0;
            clr_done     <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (xfer) begin
                        case (bus.in_data)
                            C_CR: cursor_col <= 4'd0;
                            C_LF: begin
                                cursor_col <= 4'd0;
                                cursor_row <= cursor_row + 2'd1;
                            end
                            C_BS: begin
                                if (cursor_col != 4'd0) begin
                                    cursor_col <= cursor_col - 4'd1;
                                end else if (cursor_row != 2'd0) begin
                                    cursor_row <= cursor_row - 2'd1;
                                    cursor_col <= 4'd15;
                                end
                            end
                            C_FF: begin
                                // address 0 goes out on the handshake edge itself
                                state        <= S_CLEAR;
                                busy         <= 1'b1;
                                bus.in_ready <= 1'b0;
                                bus.wr_en    <= 1'b1;
                                bus.wr_addr  <= 6'd0;
                                bus.wr_data  <= FILL_CHAR;
                                clr_cnt      <= 6'd1;
                                clr_done     <= 1'b0;
                            end
                            default: begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_addr <= {cursor_row, cursor_col};
                                bus.wr_data <= bus.in_data;
                                cursor_col  <= cursor_col + 4'd1;
                                if (cursor_col == 4'd15) cursor_row <= cursor_row + 2'd1;
                            end
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (clr_done) begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                        cursor_row   <= 2'd0;
                        cursor_col   <= 4'd0;
                        clr_done     <= 1'b0;
                    end else begin
                        // terminal flag stops the 6-bit counter from revisiting address 0
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= clr_cnt;
                        bus.wr_data <= FILL_CHAR;
                        clr_cnt     <= clr_cnt + 6'd1;
                        clr_done    <= (clr_cnt == 6'd63);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed self-checking bench for lcd_text_writer: reset clear, streaming,
// cursor wrap, control codes, FF backpressure and reset during a clear.
module tb_lcd_text_writer;
    logic clk;
    logic rst_n;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic busy;

    int checks = 0;
    int passes = 0;

    logic [5:0] q_addr[$];
    logic [7:0] q_data[$];

    lcd_text_writer_if bus ();

    lcd_text_writer #(.FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            q_addr.push_back(bus.wr_addr);
            q_data.push_back(bus.wr_data);
        end
    end

    function automatic int clear_bad(input int exp_size);
        int n;
        n = 0;
        if (q_addr.size() != exp_size) return 999;
        for (int i = 0; i < 64; i++)
            if (q_addr[i] != 6'(i) || q_data[i] != 8'h20) n++;
        return n;
    endfunction

    task automatic q_clear();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // steps until in_ready rises; lo counts cycles seen with in_ready low
    task automatic wait_idle(output int lo, output bit to);
        lo = 0;
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.in_ready) begin
                to = 1'b0;
                break;
            end
            lo++;
        end
    endtask

    task automatic do_clear(output bit to);
        int lo;
        send(8'h0C);
        wait_idle(lo, to);
    endtask

    task automatic test_reset();
        int lo;
        bit to;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_addr !== 6'd0 || bus.wr_data !== 8'd0)
            $display("FAIL reset_outs: rdy=%b en=%b addr=%0d data=%h want 0/0/0/00", bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data);
        else passes++;
        checks++; if (busy !== 1'b1 || cursor_row !== 2'd0 || cursor_col !== 4'd0)
            $display("FAIL reset_busy_cursor: busy=%b cur=(%0d,%0d) want 1,(0,0)", busy, cursor_row, cursor_col);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        q_clear();
        rst_n = 1'b1;
        wait_idle(lo, to);
        checks++; if (to !== 1'b0) $display("FAIL reset_clear_timeout: got timeout want completion");
        else passes++;
        checks++; if (lo !== 64) $display("FAIL reset_clear_len: got %0d busy cycles want 64", lo);
        else passes++;
        checks++; if (clear_bad(64) !== 0) $display("FAIL reset_clear_writes: got %0d bad (n=%0d) want 0", clear_bad(64), q_addr.size());
        else passes++;
        checks++; if (busy !== 1'b0 || bus.wr_en !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0)
            $display("FAIL reset_clear_end: busy=%b en=%b cur=(%0d,%0d) want 0,0,(0,0)", busy, bus.wr_en, cursor_row, cursor_col);
        else passes++;
    endtask

    task automatic test_hello();
        logic [7:0] h [5];
        h = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = h[i];
            @(posedge clk); #1;
            checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'(i) || bus.wr_data !== h[i])
                $display("FAIL hello_wr%0d: en=%b addr=%0d data=%h want 1,%0d,%h", i, bus.wr_en, bus.wr_addr, bus.wr_data, i, h[i]);
            else passes++;
        end
        bus.in_valid = 1'b0;
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd5)
            $display("FAIL hello_cursor: got (%0d,%0d) want (0,5)", cursor_row, cursor_col);
        else passes++;
        @(posedge clk); #1;
        checks++; if (bus.wr_en !== 1'b0) $display("FAIL hello_idle_wren: got %b want 0", bus.wr_en);
        else passes++;
    endtask

    task automatic test_wrap();
        bit to;
        do_clear(to);
        checks++; if (to !== 1'b0) $display("FAIL wrap_clear_timeout: got timeout want completion");
        else passes++;
        for (int i = 0; i < 17; i++) send(8'h61 + 8'(i));
        checks++; if (bus.wr_addr !== 6'd16 || bus.wr_data !== 8'h71)
            $display("FAIL wrap_17th: addr=%0d data=%h want 16,71", bus.wr_addr, bus.wr_data);
        else passes++;
        checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd1)
            $display("FAIL wrap_cursor17: got (%0d,%0d) want (1,1)", cursor_row, cursor_col);
        else passes++;
        for (int i = 0; i < 47; i++) send(8'h2E);
        checks++; if (bus.wr_addr !== 6'd63 || cursor_row !== 2'd0 || cursor_col !== 4'd0)
            $display("FAIL wrap_last: addr=%0d cur=(%0d,%0d) want 63,(0,0)", bus.wr_addr, cursor_row, cursor_col);
        else passes++;
        send(8'h5A);
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'd0 || bus.wr_data !== 8'h5A || cursor_col !== 4'd1 || cursor_row !== 2'd0)
            $display("FAIL wrap_around: en=%b addr=%0d data=%h cur=(%0d,%0d) want 1,0,5a,(0,1)", bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col);
        else passes++;
    endtask

    task automatic test_control();
        bit to;
        do_clear(to);
        checks++; if (to !== 1'b0) $display("FAIL ctl_clear_timeout: got timeout want completion");
        else passes++;
        for (int i = 0; i < 39; i++) send(8'h30);
        checks++; if (cursor_row !== 2'd2 || cursor_col !== 4'd7)
            $display("FAIL ctl_pos: got (%0d,%0d) want (2,7)", cursor_row, cursor_col);
        else passes++;
        @(negedge clk); #1;
        q_clear();
        @(posedge clk); #1;
        send(8'h0D);
        send(8'h0A);
        @(negedge clk); #1;
        checks++; if (q_addr.size() !== 0) $display("FAIL ctl_crlf_writes: got %0d writes want 0", q_addr.size());
        else passes++;
        checks++; if (cursor_row !== 2'd3 || cursor_col !== 4'd0)
            $display("FAIL ctl_crlf_cursor: got (%0d,%0d) want (3,0)", cursor_row, cursor_col);
        else passes++;
        send(8'h08);
        checks++; if (cursor_row !== 2'd2 || cursor_col !== 4'd15 || bus.wr_en !== 1'b0)
            $display("FAIL ctl_bs_wrap: cur=(%0d,%0d) en=%b want (2,15),0", cursor_row, cursor_col, bus.wr_en);
        else passes++;
        do_clear(to);
        send(8'h08);
        checks++; if (to !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0 || bus.wr_en !== 1'b0)
            $display("FAIL ctl_bs_origin: to=%b cur=(%0d,%0d) en=%b want 0,(0,0),0", to, cursor_row, cursor_col, bus.wr_en);
        else passes++;
        send(8'h51);
        send(8'h08);
        checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0)
            $display("FAIL ctl_bs_col: got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
        else passes++;
        send(8'h1B);
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'd0 || bus.wr_data !== 8'h1B)
            $display("FAIL ctl_ctrl_verbatim: en=%b addr=%0d data=%h want 1,0,1b", bus.wr_en, bus.wr_addr, bus.wr_data);
        else passes++;
        send(8'hFF);
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'd1 || bus.wr_data !== 8'hFF || cursor_col !== 4'd2)
            $display("FAIL ctl_high_verbatim: en=%b addr=%0d data=%h col=%0d want 1,1,ff,2", bus.wr_en, bus.wr_addr, bus.wr_data, cursor_col);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lo;
        bit to;
        @(negedge clk); #1;
        q_clear();
        @(posedge clk); #1;
        bus.in_data  = 8'h0C;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'd0 || bus.in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_ff_first: en=%b addr=%0d rdy=%b busy=%b want 1,0,0,1", bus.wr_en, bus.wr_addr, bus.in_ready, busy);
        else passes++;
        bus.in_data = 8'h41;
        wait_idle(lo, to);
        lo = lo + 1;
        checks++; if (to !== 1'b0 || lo !== 64)
            $display("FAIL b2b_ready_low: to=%b got %0d cycles want 0,64", to, lo);
        else passes++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'd0 || bus.wr_data !== 8'h41 || cursor_row !== 2'd0 || cursor_col !== 4'd1)
            $display("FAIL b2b_held_byte: en=%b addr=%0d data=%h cur=(%0d,%0d) want 1,0,41,(0,1)", bus.wr_en, bus.wr_addr, bus.wr_data, cursor_row, cursor_col);
        else passes++;
        @(negedge clk); #1;
        checks++; if (clear_bad(65) !== 0 || q_data[64] !== 8'h41)
            $display("FAIL b2b_write_seq: got %0d bad, n=%0d want 0 bad, n=65 ending 41", clear_bad(65), q_addr.size());
        else passes++;
    endtask

    task automatic test_reset_mid_clear();
        int lo;
        bit to;
        bit hit;
        send(8'h0C);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.wr_en && bus.wr_addr == 6'd29) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (hit !== 1'b1) $display("FAIL mid_reach29: got no write at 29 want write at 29");
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 6'd0 || bus.in_ready !== 1'b0 || busy !== 1'b1 || cursor_col !== 4'd0)
            $display("FAIL mid_async_reset: en=%b addr=%0d rdy=%b busy=%b col=%0d want 0,0,0,1,0", bus.wr_en, bus.wr_addr, bus.in_ready, busy, cursor_col);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        q_clear();
        rst_n = 1'b1;
        wait_idle(lo, to);
        checks++; if (to !== 1'b0 || lo !== 64)
            $display("FAIL mid_restart_len: to=%b got %0d want 0,64", to, lo);
        else passes++;
        checks++; if (clear_bad(64) !== 0)
            $display("FAIL mid_restart_writes: got %0d bad (n=%0d) want 0", clear_bad(64), q_addr.size());
        else passes++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b1;
        #2;
        test_reset();
        test_hello();
        test_wrap();
        test_control();
        test_back_to_back();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
